// File: rtl/sd_photo_wr_ctrl_if.sv
// ---------------------------------------------------------------------------
// sd_photo_wr_ctrl_if
// Bundles the SD-reader side inputs and the backpressured memory write port
// seen by sd_photo_wr_ctrl.
//   rd_start_en     sector-read start pulse from the photo sequencer
//   photo_load_cnt  image index (0 / out of range = background, else sprite)
//   rd_busy         SD reader busy; a falling edge closes a sector
//   rd_val_en       one-cycle strobe per 16-bit SD data word
//   rd_val_data     SD data word (RGB565)
//   wr_ready        memory port accepts a word this cycle
//   wr_en/wr_addr/wr_data  registered write request toward memory
// master: the write controller; slave: the SD source plus memory sink.
// ---------------------------------------------------------------------------
interface sd_photo_wr_ctrl_if #(
  parameter int ADDR_W = 24
) ();
  logic              rd_start_en;
  logic [7:0]        photo_load_cnt;
  logic              rd_busy;
  logic              rd_val_en;
  logic [15:0]       rd_val_data;
  logic              wr_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  modport master (
    input  rd_start_en, photo_load_cnt, rd_busy, rd_val_en, rd_val_data,
    input  wr_ready,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    output rd_start_en, photo_load_cnt, rd_busy, rd_val_en, rd_val_data,
    output wr_ready,
    input  wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/sd_photo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// sd_photo_wr_ctrl
// Takes the RGB565 words streamed out of SD sectors and writes them into the
// frame/sprite memory. Image type and slot come from photo_load_cnt at the
// start pulse. A 16-word buffer (output register + internal FIFO) absorbs
// write-port stalls, since the SD stream cannot be paused.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          sd_photo_wr_ctrl_if.master (SD inputs + memory write port)
//   busy         image load in progress
//   img_done     one-cycle pulse once the last word of an image is written
//   loaded_idx   photo_load_cnt of the last completed image
//   err_ovf      sticky: word arrived with the buffer full (word dropped)
//   err_stray    sticky: word arrived outside an image or past its length
//   err_sector   sticky: sector closed with a word count other than 256
// ---------------------------------------------------------------------------
module sd_photo_wr_ctrl #(
  parameter int ADDR_W    = 24,
  parameter int BG_WORDS  = 307200,
  parameter int SPR_WORDS = 24320,
  parameter int SPR_SLOT  = 32768,
  parameter int PHOTO_NUM = 46
) (
  input  logic               clk,
  input  logic               rst_n,
  sd_photo_wr_ctrl_if.master bus,
  output logic               busy,
  output logic               img_done,
  output logic [7:0]         loaded_idx,
  output logic               err_ovf,
  output logic               err_stray,
  output logic               err_sector
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [18:0]       r_len;
  logic [7:0]        r_idx;
  logic [18:0]       r_word_cnt;
  logic [8:0]        r_sec_wcnt;
  logic              r_rd_busy;

  // Buffer: r_wr_* is the head entry, r_mem holds up to 15 more words.
  logic [ADDR_W+15:0] r_mem [16];
  logic [3:0]         r_wptr, r_rptr;
  logic [4:0]         r_mcnt;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [15:0]        r_wr_data;

  logic               r_busy, r_img_done, r_err_ovf, r_err_stray, r_err_sector;
  logic [7:0]         r_loaded_idx;

  logic              w_start, w_take, w_push, w_pop, w_full, w_ovf, w_stray;
  logic              w_fall, w_sec_err, w_done, w_drained;
  logic              w_load_out, w_mem_rd, w_mem_wr;
  logic [4:0]        w_occ;
  logic [18:0]       w_cnt_inc;
  logic [8:0]        w_sec_sum;
  logic [ADDR_W-1:0] w_in_addr;

  function automatic logic f_is_sprite(input logic [7:0] idx);
    f_is_sprite = (idx != 8'd0) && (int'(idx) <= PHOTO_NUM);
  endfunction

  function automatic logic [ADDR_W-1:0] f_base(input logic [7:0] idx);
    if (f_is_sprite(idx))
      f_base = ADDR_W'(BG_WORDS) + ADDR_W'(idx - 8'd1) * ADDR_W'(SPR_SLOT);
    else
      f_base = '0;
  endfunction

  function automatic logic [18:0] f_len(input logic [7:0] idx);
    f_len = f_is_sprite(idx) ? 19'(SPR_WORDS) : 19'(BG_WORDS);
  endfunction

  assign w_pop     = r_wr_en && bus.wr_ready;
  assign w_occ     = r_mcnt + {4'd0, r_wr_en};
  assign w_full    = (w_occ == 5'd16);
  assign w_start   = (r_state == S_IDLE) && bus.rd_start_en;
  assign w_take    = (r_state == S_ACTIVE) && bus.rd_val_en && (r_word_cnt < r_len);
  // A pop in the same cycle frees a slot, so a full buffer can still accept.
  assign w_push    = w_take && (!w_full || w_pop);
  assign w_ovf     = w_take && w_full && !w_pop;
  assign w_stray   = bus.rd_val_en && !w_take;
  assign w_fall    = r_rd_busy && !bus.rd_busy;
  // The word arriving together with the busy fall belongs to this sector.
  assign w_sec_sum = r_sec_wcnt + {8'd0, w_take};
  assign w_sec_err = (r_state == S_ACTIVE) && w_fall && (w_sec_sum != 9'd256);
  assign w_cnt_inc = r_word_cnt + 19'd1;
  assign w_in_addr = r_base + ADDR_W'(r_word_cnt);
  // Empty after this cycle's transfer: lets img_done follow the last write by one cycle.
  assign w_drained = (r_mcnt == 5'd0) && (!r_wr_en || w_pop);

  assign w_load_out = !r_wr_en || w_pop;
  assign w_mem_rd   = w_load_out && (r_mcnt != 5'd0);
  // Bypass the memory when the head slot is free and nothing is queued.
  assign w_mem_wr   = w_push && !(w_load_out && (r_mcnt == 5'd0));

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE:   if (w_start) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_take && (w_cnt_inc == r_len)) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (w_drained) begin
                  w_done      = 1'b1;
                  w_state_nxt = S_IDLE;
                end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_len        <= '0;
      r_idx        <= '0;
      r_word_cnt   <= '0;
      r_sec_wcnt   <= '0;
      r_rd_busy    <= 1'b0;
      r_busy       <= 1'b0;
      r_img_done   <= 1'b0;
      r_loaded_idx <= '0;
      r_err_ovf    <= 1'b0;
      r_err_stray  <= 1'b0;
      r_err_sector <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_busy  <= bus.rd_busy;
      r_img_done <= w_done;
      r_busy     <= (w_state_nxt != S_IDLE) || w_done;
      if (w_start) begin
        r_base     <= f_base(bus.photo_load_cnt);
        r_len      <= f_len(bus.photo_load_cnt);
        r_idx      <= bus.photo_load_cnt;
        r_word_cnt <= '0;
        r_sec_wcnt <= '0;
      end else if (r_state == S_ACTIVE) begin
        if (w_take) r_word_cnt <= w_cnt_inc;
        if (w_fall) r_sec_wcnt <= '0;
        else        r_sec_wcnt <= w_sec_sum;
      end
      if (w_done)    r_loaded_idx <= r_idx;
      if (w_ovf)     r_err_ovf    <= 1'b1;
      if (w_stray)   r_err_stray  <= 1'b1;
      if (w_sec_err) r_err_sector <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_mcnt    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      if (w_load_out) begin
        if (w_mem_rd) begin
          r_wr_en                <= 1'b1;
          {r_wr_addr, r_wr_data} <= r_mem[r_rptr];
        end else if (w_push) begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= w_in_addr;
          r_wr_data <= bus.rd_val_data;
        end else begin
          r_wr_en <= 1'b0;
        end
      end
      if (w_mem_rd) r_rptr <= r_rptr + 4'd1;
      if (w_mem_wr) r_wptr <= r_wptr + 4'd1;
      case ({w_mem_wr, w_mem_rd})
        2'b10:   r_mcnt <= r_mcnt + 5'd1;
        2'b01:   r_mcnt <= r_mcnt - 5'd1;
        default: r_mcnt <= r_mcnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_wr) r_mem[r_wptr] <= {w_in_addr, bus.rd_val_data};
  end

  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  assign busy        = r_busy;
  assign img_done    = r_img_done;
  assign loaded_idx  = r_loaded_idx;
  assign err_ovf     = r_err_ovf;
  assign err_stray   = r_err_stray;
  assign err_sector  = r_err_sector;

endmodule

// File: tb/tb_sd_photo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sd_photo_wr_ctrl
// Directed bench for sd_photo_wr_ctrl: sprite load with write stalls and an
// overflow burst, stray word in idle, short sector inside a partial
// background load, reset mid-image, then a clean sprite load.
// ---------------------------------------------------------------------------
module tb_sd_photo_wr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy, img_done, err_ovf, err_stray, err_sector;
  logic [7:0] loaded_idx;

  sd_photo_wr_ctrl_if #(.ADDR_W(24)) bus ();

  sd_photo_wr_ctrl #(.ADDR_W(24)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .img_done   (img_done),
    .loaded_idx (loaded_idx),
    .err_ovf    (err_ovf),
    .err_stray  (err_stray),
    .err_sector (err_sector)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [39:0] q[$];
  int          n_wr = 0, n_bad = 0, n_done = 0, cyc = 0;
  int          last_xfer_cyc = 0, done_cyc = 0;
  logic        busy_at_done = 1'b0, have_first = 1'b0;
  logic [23:0] first_addr = '0, last_addr = '0, base_e = '0;
  int          woff = 0;
  bit          lat_chk = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // One clock: sample at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    logic [39:0] e;
    @(negedge clk);
    if (bus.wr_en && bus.wr_ready) begin
      n_wr++;
      if (!have_first) begin
        have_first = 1'b1;
        first_addr = bus.wr_addr;
      end
      last_addr     = bus.wr_addr;
      last_xfer_cyc = cyc;
      if (q.size() == 0) n_bad++;
      else begin
        e = q.pop_front();
        if ({bus.wr_addr, bus.wr_data} !== e) n_bad++;
      end
    end
    if (img_done) begin
      n_done++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic word(input bit keep);
    logic [15:0] d;
    d = 16'($urandom());
    bus.rd_val_en   = 1'b1;
    bus.rd_val_data = d;
    if (keep) q.push_back({base_e + 24'(woff), d});
    woff++;
    tick();
    bus.rd_val_en = 1'b0;
  endtask

  // Start pulse, optional idle cycles, n words (ready low for stall words,
  // words in [drop_from,drop_to) expected lost), then the busy fall.
  task automatic sector(input int n, input int pre_idle, input int stall_at,
                        input int stall_len, input int drop_from, input int drop_to,
                        input bit do_end);
    bus.rd_busy     = 1'b1;
    bus.rd_start_en = 1'b1;
    tick();
    bus.rd_start_en = 1'b0;
    for (int k = 0; k < pre_idle; k++) tick();
    for (int i = 0; i < n; i++) begin
      bus.wr_ready = !((i >= stall_at) && (i < stall_at + stall_len));
      word(!((i >= drop_from) && (i < drop_to)));
      if (lat_chk && i == 0) begin
        chk_eq("first_word_wr_en", 32'(bus.wr_en), 32'd1);
        chk_eq("first_word_addr", 32'(bus.wr_addr), 32'(base_e));
        lat_chk = 1'b0;
      end
    end
    bus.wr_ready = 1'b1;
    if (do_end) begin
      bus.rd_busy = 1'b0;
      tick();
    end
  endtask

  task automatic new_load(input logic [7:0] idx, input logic [23:0] base);
    bus.photo_load_cnt = idx;
    base_e     = base;
    woff       = 0;
    n_wr       = 0;
    n_bad      = 0;
    have_first = 1'b0;
    q.delete();
  endtask

  task automatic wait_done(input string tag, input int d0);
    int k;
    k = 0;
    while (n_done == d0 && k < 200) begin
      tick();
      k++;
    end
    chk_eq(tag, 32'(n_done - d0), 32'd1);
  endtask

  initial begin
    int d0;
    bus.rd_start_en    = 1'b0;
    bus.photo_load_cnt = 8'd0;
    bus.rd_busy        = 1'b0;
    bus.rd_val_en      = 1'b0;
    bus.rd_val_data    = 16'd0;
    bus.wr_ready       = 1'b1;
    #12;
    chk_eq("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_errs", 32'({err_ovf, err_stray, err_sector}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); tick();

    // Sprite 3: 10-cycle stall in sector 2, 20-cycle stall over a 20-word burst in sector 4.
    new_load(8'd3, 24'd372736);
    d0 = n_done;
    for (int s = 0; s < 95; s++) begin
      if (s == 2)      sector(256, 0, 100, 10, -1, -1, 1'b1);
      else if (s == 4) sector(256, 20, 0, 20, 16, 20, 1'b1);
      else             sector(256, 0, -1, 0, -1, -1, 1'b1);
      if (s == 0) chk_eq("sp3_busy", 32'(busy), 32'd1);
    end
    wait_done("sp3_done", d0);
    chk_eq("sp3_done_lat", 32'(done_cyc - last_xfer_cyc), 32'd1);
    chk_eq("sp3_busy_at_done", 32'(busy_at_done), 32'd1);
    tick();
    chk_eq("sp3_busy_after", 32'(busy), 32'd0);
    chk_eq("sp3_nwr", 32'(n_wr), 32'd24316);
    chk_eq("sp3_bad", 32'(n_bad), 32'd0);
    chk_eq("sp3_first", 32'(first_addr), 32'd372736);
    chk_eq("sp3_last", 32'(last_addr), 32'd397055);
    chk_eq("sp3_idx", 32'(loaded_idx), 32'd3);
    chk_eq("sp3_ovf", 32'(err_ovf), 32'd1);
    chk_eq("sp3_stray", 32'(err_stray), 32'd0);
    chk_eq("sp3_sector", 32'(err_sector), 32'd0);

    // Stray word in idle.
    d0 = n_wr;
    word(1'b0);
    tick(); tick(); tick();
    chk_eq("stray_nwr", 32'(n_wr - d0), 32'd0);
    chk_eq("stray_flag", 32'(err_stray), 32'd1);

    // Background: short sector, then streaming up to 5000 words, then reset.
    new_load(8'd0, 24'd0);
    sector(255, 0, -1, 0, -1, -1, 1'b1);
    chk_eq("short_sector", 32'(err_sector), 32'd1);
    for (int s = 0; s < 18; s++) sector(256, 0, -1, 0, -1, -1, 1'b1);
    sector(137, 0, -1, 0, -1, -1, 1'b0);
    tick();
    chk_eq("bg_nwr", 32'(n_wr), 32'd5000);
    chk_eq("bg_bad", 32'(n_bad), 32'd0);
    chk_eq("bg_first", 32'(first_addr), 32'd0);
    chk_eq("bg_last", 32'(last_addr), 32'd4999);
    bus.rd_val_en = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk_eq("mid_rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk_eq("mid_rst_wr_data", 32'(bus.wr_data), 32'd0);
    chk_eq("mid_rst_busy", 32'(busy), 32'd0);
    chk_eq("mid_rst_done", 32'(img_done), 32'd0);
    chk_eq("mid_rst_idx", 32'(loaded_idx), 32'd0);
    chk_eq("mid_rst_errs", 32'({err_ovf, err_stray, err_sector}), 32'd0);
    bus.rd_val_en = 1'b0;
    bus.rd_busy   = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Clean sprite 1 load after reset.
    new_load(8'd1, 24'd307200);
    d0 = n_done;
    lat_chk = 1'b1;
    for (int s = 0; s < 95; s++) sector(256, 0, -1, 0, -1, -1, 1'b1);
    wait_done("sp1_done", d0);
    chk_eq("sp1_done_lat", 32'(done_cyc - last_xfer_cyc), 32'd1);
    tick();
    chk_eq("sp1_nwr", 32'(n_wr), 32'd24320);
    chk_eq("sp1_bad", 32'(n_bad), 32'd0);
    chk_eq("sp1_first", 32'(first_addr), 32'd307200);
    chk_eq("sp1_last", 32'(last_addr), 32'd331519);
    chk_eq("sp1_idx", 32'(loaded_idx), 32'd1);
    chk_eq("sp1_errs", 32'({err_ovf, err_stray, err_sector}), 32'd0);
    chk_eq("sp1_busy_after", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
